// File: rtl/inference_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : inference_sequencer
//  Purpose  : Top-level scheduler for the BNN inference path. Captures a
//             64 x 2-bit frame on go, runs the layer-1 engine, drains its 48
//             activations into a packed buffer, runs the layer-2 engine, then
//             scans the class scores (signed argmax, lowest index on ties).
//             A watchdog aborts to an error state if an engine stalls.
//  Ports    : clk, rst (sync, active-high), go, pixels_in[127:0]
//             busy, done, class_out[3:0], err
//             l1_start, l1_done, l1_pixels[127:0], l1_raddr[5:0], l1_rdata[1:0]
//             l2_start, l2_done, l2_act_flat[2*N_HID-1:0], l2_raddr[3:0],
//             l2_rdata[SCORE_W-1:0] (signed)
//  Revision : 1.0 - initial release
// ============================================================================
module inference_sequencer #(
    parameter int N_HID   = 48,
    parameter int N_OUT   = 10,
    parameter int SCORE_W = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic [127:0]              pixels_in,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                class_out,
    output logic                      err,
    output logic                      l1_start,
    input  logic                      l1_done,
    output logic [127:0]              l1_pixels,
    output logic [5:0]                l1_raddr,
    input  logic [1:0]                l1_rdata,
    output logic                      l2_start,
    input  logic                      l2_done,
    output logic [2*N_HID-1:0]        l2_act_flat,
    output logic [3:0]                l2_raddr,
    input  logic signed [SCORE_W-1:0] l2_rdata
);

    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX  = c_WD_W'(TIMEOUT);
    localparam logic [5:0]        c_L1_LAST = 6'(N_HID - 1);
    localparam logic [3:0]        c_L2_LAST = 4'(N_OUT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_L1_ARM  = 4'd1,
        S_L1_WAIT = 4'd2,
        S_XFER    = 4'd3,
        S_L2_ARM  = 4'd4,
        S_L2_WAIT = 4'd5,
        S_SCAN    = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t                     r_state,    w_state;
    logic                       r_busy,     w_busy;
    logic                       r_done,     w_done;
    logic                       r_err,      w_err;
    logic [3:0]                 r_class,    w_class;
    logic                       r_l1_start, w_l1_start;
    logic                       r_l2_start, w_l2_start;
    logic [127:0]               r_pixels,   w_pixels;
    logic [5:0]                 r_l1_raddr, w_l1_raddr;   // doubles as transfer index
    logic [3:0]                 r_l2_raddr, w_l2_raddr;   // doubles as scan index
    logic [2*N_HID-1:0]         r_act,      w_act;
    logic [c_WD_W-1:0]          r_wd,       w_wd;
    logic signed [SCORE_W-1:0]  r_best,     w_best;
    logic [3:0]                 r_best_idx, w_best_idx;
    logic                       w_fail;
    logic                       w_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_class    <= 4'd0;
            r_l1_start <= 1'b0;
            r_l2_start <= 1'b0;
            r_pixels   <= '0;
            r_l1_raddr <= '0;
            r_l2_raddr <= '0;
            r_act      <= '0;
            r_wd       <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
        end else begin
            r_state    <= w_state;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_class    <= w_class;
            r_l1_start <= w_l1_start;
            r_l2_start <= w_l2_start;
            r_pixels   <= w_pixels;
            r_l1_raddr <= w_l1_raddr;
            r_l2_raddr <= w_l2_raddr;
            r_act      <= w_act;
            r_wd       <= w_wd;
            r_best     <= w_best;
            r_best_idx <= w_best_idx;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_busy     = r_busy;
        w_done     = r_done;
        w_err      = r_err;
        w_class    = r_class;
        w_l1_start = r_l1_start;
        w_l2_start = r_l2_start;
        w_pixels   = r_pixels;
        w_l1_raddr = r_l1_raddr;
        w_l2_raddr = r_l2_raddr;
        w_act      = r_act;
        w_wd       = r_wd;
        w_best     = r_best;
        w_best_idx = r_best_idx;
        w_fail     = 1'b0;
        // First score always loads; later ones must be strictly greater so
        // ties stay with the lowest index.
        w_take     = (r_l2_raddr == 4'd0) || (l2_rdata > r_best);

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    w_pixels = pixels_in;
                    w_busy   = 1'b1;
                    w_done   = 1'b0;
                    w_err    = 1'b0;
                    w_wd     = '0;
                    w_state  = S_L1_ARM;
                end
            end
            S_L1_ARM: begin
                // Hold off until a done level left over from a prior run drops.
                if (!l1_done) begin
                    w_l1_start = 1'b1;
                    w_wd       = '0;
                    w_state    = S_L1_WAIT;
                end else if (r_wd == c_WD_MAX) begin
                    w_fail = 1'b1;
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end
            S_L1_WAIT: begin
                if (l1_done) begin
                    w_l1_start = 1'b0;
                    w_l1_raddr = '0;
                    w_state    = S_XFER;
                end else if (r_wd == c_WD_MAX) begin
                    w_fail = 1'b1;
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end
            S_XFER: begin
                w_act[2*r_l1_raddr +: 2] = l1_rdata;
                if (r_l1_raddr == c_L1_LAST) begin
                    w_wd    = '0;
                    w_state = S_L2_ARM;
                end else begin
                    w_l1_raddr = r_l1_raddr + 6'd1;
                end
            end
            S_L2_ARM: begin
                if (!l2_done) begin
                    w_l2_start = 1'b1;
                    w_wd       = '0;
                    w_state    = S_L2_WAIT;
                end else if (r_wd == c_WD_MAX) begin
                    w_fail = 1'b1;
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end
            S_L2_WAIT: begin
                if (l2_done) begin
                    w_l2_start = 1'b0;
                    w_l2_raddr = '0;
                    w_state    = S_SCAN;
                end else if (r_wd == c_WD_MAX) begin
                    w_fail = 1'b1;
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end
            S_SCAN: begin
                if (w_take) begin
                    w_best     = l2_rdata;
                    w_best_idx = r_l2_raddr;
                end
                if (r_l2_raddr == c_L2_LAST) begin
                    w_class = w_best_idx;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_DONE;
                end else begin
                    w_l2_raddr = r_l2_raddr + 4'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_fail) begin
            w_state    = S_ERR;
            w_done     = 1'b1;
            w_err      = 1'b1;
            w_busy     = 1'b0;
            w_class    = 4'hF;
            w_l1_start = 1'b0;
            w_l2_start = 1'b0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign class_out   = r_class;
    assign l1_start    = r_l1_start;
    assign l2_start    = r_l2_start;
    assign l1_pixels   = r_pixels;
    assign l1_raddr    = r_l1_raddr;
    assign l2_raddr    = r_l2_raddr;
    assign l2_act_flat = r_act;

endmodule
`default_nettype wire

// File: tb/tb_inference_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inference_sequencer
//  Purpose  : Directed self-checking bench for inference_sequencer. Instance A
//             uses default parameters; instance B uses TIMEOUT=20 with a
//             layer-2 engine that can be made to stall.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inference_sequencer;

    localparam int L1_DLY_A = 100;
    localparam int L2_DLY_A = 50;
    localparam int L1_DLY_B = 5;
    localparam int L2_DLY_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         go_a = 1'b0, go_b = 1'b0;
    logic [127:0] pixels_in = '0;

    // Instance A signals
    logic              busy_a, done_a, err_a, l1_start_a, l2_start_a, l1_done_a, l2_done_a;
    logic [3:0]        class_a, l2_raddr_a;
    logic [127:0]      l1_pixels_a;
    logic [5:0]        l1_raddr_a;
    logic [1:0]        l1_rdata_a;
    logic [95:0]       act_a;
    logic signed [7:0] l2_rdata_a;

    // Instance B signals
    logic              busy_b, done_b, err_b, l1_start_b, l2_start_b, l1_done_b, l2_done_b;
    logic [3:0]        class_b, l2_raddr_b;
    logic [127:0]      l1_pixels_b;
    logic [5:0]        l1_raddr_b;
    logic [1:0]        l1_rdata_b;
    logic [95:0]       act_b;
    logic signed [7:0] l2_rdata_b;

    inference_sequencer dut_a (
        .clk(clk), .rst(rst), .go(go_a), .pixels_in(pixels_in),
        .busy(busy_a), .done(done_a), .class_out(class_a), .err(err_a),
        .l1_start(l1_start_a), .l1_done(l1_done_a), .l1_pixels(l1_pixels_a),
        .l1_raddr(l1_raddr_a), .l1_rdata(l1_rdata_a),
        .l2_start(l2_start_a), .l2_done(l2_done_a), .l2_act_flat(act_a),
        .l2_raddr(l2_raddr_a), .l2_rdata(l2_rdata_a)
    );

    inference_sequencer #(.TIMEOUT(20)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .pixels_in(pixels_in),
        .busy(busy_b), .done(done_b), .class_out(class_b), .err(err_b),
        .l1_start(l1_start_b), .l1_done(l1_done_b), .l1_pixels(l1_pixels_b),
        .l1_raddr(l1_raddr_b), .l1_rdata(l1_rdata_b),
        .l2_start(l2_start_b), .l2_done(l2_done_b), .l2_act_flat(act_b),
        .l2_raddr(l2_raddr_b), .l2_rdata(l2_rdata_b)
    );

    // ---------------- engine models ----------------
    logic signed [7:0] scores [10];
    bit l1_stale_a = 1'b0;
    bit l2_never_b = 1'b0;
    int l1_cnt_a = 0, l2_cnt_a = 0, l1_cnt_b = 0, l2_cnt_b = 0;

    function automatic logic signed [7:0] score_of(input logic [3:0] a);
        if (a < 4'd10) return scores[a];
        return 8'sd0;
    endfunction

    always @(posedge clk) begin
        l1_cnt_a <= l1_start_a ? l1_cnt_a + 1 : 0;
        l2_cnt_a <= l2_start_a ? l2_cnt_a + 1 : 0;
        l1_cnt_b <= l1_start_b ? l1_cnt_b + 1 : 0;
        l2_cnt_b <= l2_start_b ? l2_cnt_b + 1 : 0;
    end

    assign l1_done_a  = l1_stale_a | (l1_start_a & (l1_cnt_a >= L1_DLY_A));
    assign l2_done_a  = l2_start_a & (l2_cnt_a >= L2_DLY_A);
    assign l1_done_b  = l1_start_b & (l1_cnt_b >= L1_DLY_B);
    assign l2_done_b  = !l2_never_b & l2_start_b & (l2_cnt_b >= L2_DLY_B);
    assign l1_rdata_a = 2'(l1_raddr_a % 6'd3);
    assign l1_rdata_b = 2'(l1_raddr_b % 6'd3);
    assign l2_rdata_a = score_of(l2_raddr_a);
    assign l2_rdata_b = score_of(l2_raddr_b);

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [95:0] exp_act;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_t2_scores();
        scores[0] = -8'sd3; scores[1] = 8'sd5; scores[2] = 8'sd2; scores[3] = 8'sd9;
        scores[4] = 8'sd9;  scores[5] = 8'sd0; scores[6] = -8'sd8; scores[7] = 8'sd1;
        scores[8] = 8'sd4;  scores[9] = 8'sd7;
    endtask

    task automatic pulse_go_a(input logic [127:0] pix);
        @(negedge clk);
        pixels_in = pix;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
    endtask

    task automatic pulse_go_b(input logic [127:0] pix);
        @(negedge clk);
        pixels_in = pix;
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int max_cyc);
        int n = 0;
        while (!done_a && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(done_a), 128'd1);
    endtask

    task automatic wait_done_b(input string tag, input int max_cyc);
        int n = 0;
        while (!done_b && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(done_b), 128'd1);
    endtask

    localparam logic [127:0] P1 = {4{32'hDEADBEEF}};
    localparam logic [127:0] P2 = {4{32'h12345678}};
    localparam logic [127:0] P3 = {4{32'hA5A5F00F}};

    initial begin
        for (int i = 0; i < 48; i++) exp_act[2*i +: 2] = 2'(i % 3);
        set_t2_scores();

        // ---- T1: reset with go held high ----
        go_a = 1'b1; go_b = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_busy", 128'(busy_a), 128'd0);
        chk("t1_done", 128'(done_a), 128'd0);
        chk("t1_err", 128'(err_a), 128'd0);
        chk("t1_class", 128'(class_a), 128'd0);
        chk("t1_starts", 128'({l1_start_a, l2_start_a}), 128'd0);
        chk("t1_raddrs", 128'({l1_raddr_a, l2_raddr_a}), 128'd0);
        chk("t1_pixels", l1_pixels_a, 128'd0);
        chk("t1_act", 128'(act_a), 128'd0);
        go_a = 1'b0; go_b = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_idle_no_start", 128'({l1_start_a, busy_a}), 128'd0);

        // ---- T2: nominal run ----
        pulse_go_a(P1);
        chk("t2_busy", 128'(busy_a), 128'd1);
        chk("t2_capture", l1_pixels_a, P1);
        pixels_in = P2;
        @(negedge clk);
        chk("t2_capture_held", l1_pixels_a, P1);
        wait_done_a("t2_done_timeout", 1000);
        chk("t2_act", 128'(act_a), 128'(exp_act));
        chk("t2_class", 128'(class_a), 128'd3);
        chk("t2_busy_end", 128'(busy_a), 128'd0);
        chk("t2_err", 128'(err_a), 128'd0);
        chk("t2_starts_low", 128'({l1_start_a, l2_start_a}), 128'd0);

        // ---- T3: all scores equal ----
        for (int i = 0; i < 10; i++) scores[i] = -8'sd128;
        pulse_go_a(P2);
        chk("t3_done_cleared", 128'(done_a), 128'd0);
        chk("t3_old_class_held", 128'(class_a), 128'd3);
        wait_done_a("t3_done_timeout", 1000);
        chk("t3_class", 128'(class_a), 128'd0);

        // ---- T4: stale layer-1 done ----
        set_t2_scores();
        l1_stale_a = 1'b1;
        pulse_go_a(P3);
        repeat (5) @(negedge clk);
        chk("t4_start_held_off", 128'(l1_start_a), 128'd0);
        chk("t4_busy", 128'(busy_a), 128'd1);
        l1_stale_a = 1'b0;
        chk("t4_start_before_edge", 128'(l1_start_a), 128'd0);
        @(negedge clk);
        chk("t4_start_rises", 128'(l1_start_a), 128'd1);
        wait_done_a("t4_done_timeout", 1000);
        chk("t4_class", 128'(class_a), 128'd3);

        // ---- T6: go ignored mid-run, reset during transfer ----
        pulse_go_a(P3);
        begin
            int n = 0;
            while (!l1_start_a && n < 50) begin @(negedge clk); n++; end
        end
        chk("t6_l1_started", 128'(l1_start_a), 128'd1);
        pulse_go_a(P1);
        chk("t6_go_ignored_pix", l1_pixels_a, P3);
        chk("t6_go_ignored_busy", 128'({busy_a, l1_start_a}), 128'd3);
        begin
            int n = 0;
            while (l1_raddr_a != 6'd10 && n < 500) begin @(negedge clk); n++; end
        end
        chk("t6_in_xfer", 128'(l1_raddr_a), 128'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_busy", 128'(busy_a), 128'd0);
        chk("t6_rst_starts", 128'({l1_start_a, l2_start_a}), 128'd0);
        chk("t6_rst_act", 128'(act_a), 128'd0);
        chk("t6_rst_done", 128'(done_a), 128'd0);
        pulse_go_a(P2);
        chk("t6_rerun_pix", l1_pixels_a, P2);
        wait_done_a("t6_done_timeout", 1000);
        chk("t6_act", 128'(act_a), 128'(exp_act));
        chk("t6_class", 128'(class_a), 128'd3);

        // ---- T5: watchdog on stalled layer-2 (instance B, TIMEOUT=20) ----
        l2_never_b = 1'b1;
        pulse_go_b(P1);
        wait_done_b("t5_err_timeout", 500);
        chk("t5_err", 128'(err_b), 128'd1);
        chk("t5_class", 128'(class_b), 128'hF);
        chk("t5_l2_start", 128'(l2_start_b), 128'd0);
        chk("t5_busy", 128'(busy_b), 128'd0);
        l2_never_b = 1'b0;
        pulse_go_b(P2);
        chk("t5_err_cleared", 128'({err_b, done_b}), 128'd0);
        wait_done_b("t5_rerun_timeout", 500);
        chk("t5_rerun_err", 128'(err_b), 128'd0);
        chk("t5_rerun_class", 128'(class_b), 128'd3);
        chk("t5_rerun_act", 128'(act_b), 128'(exp_act));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
